// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encodings and overflow helper.
// Optional subtract/overflow support is enabled by defining SERIAL_ADDER_SUBTRACT_EN (undefined by default).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
    function automatic logic twos_ovf(input logic c_msb, input logic c_out);
        return c_msb ^ c_out;
    endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder, the basic cell of the ripple-carry slice.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_fa_chain.sv
// DIGIT-wide ripple of full adders; also exposes the carry into the top bit for overflow.
module fa_chain #(
    parameter int DIGIT = 1
) (
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb,
    input  logic             cin,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b
);

    logic [DIGIT:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout = carry_s[DIGIT];
    assign cmsb = carry_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: W-bit operands summed DIGIT bits per clock with a start/busy/done handshake.
// Define SERIAL_ADDER_SUBTRACT_EN to add the sub input and ovf output (disabled by default).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W     = 8,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic         sub,
    output logic         ovf,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y,
    output logic         cout
);

    localparam int N  = W / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state_r, state_next_s;
    logic             busy_r, done_r, busy_next_s, done_next_s;
    logic [W-1:0]     a_r, b_r, res_r, y_r, res_shift_s;
    logic             carry_r, cout_r;
    logic [CW-1:0]    cnt_r;
    logic [DIGIT-1:0] b_eff_s, slice_sum_s;
    logic             slice_cout_s, slice_cmsb_s, last_digit_s;

    assign last_digit_s = (cnt_r == CW'(N - 1));

`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic sub_r, ovf_r;
    assign b_eff_s = b_r[DIGIT-1:0] ^ {DIGIT{sub_r}};
    assign ovf     = ovf_r;
`else
    assign b_eff_s = b_r[DIGIT-1:0];
`endif

    fa_chain #(.DIGIT(DIGIT)) u_chain (
        .sum  (slice_sum_s),
        .cout (slice_cout_s),
        .cmsb (slice_cmsb_s),
        .cin  (carry_r),
        .a    (a_r[DIGIT-1:0]),
        .b    (b_eff_s)
    );

    // The new digit enters at the top, so after N shifts the result is aligned.
    if (DIGIT == W) begin : g_full
        assign res_shift_s = slice_sum_s;
    end else begin : g_part
        assign res_shift_s = {slice_sum_s, res_r[W-1:DIGIT]};
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state logic; busy/done are derived from the state being entered.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_digit_s) state_next_s = ST_DONE;
                else              state_next_s = ST_RUN;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_next_s == ST_DONE);
    end

    // Operand capture, digit-serial shifting and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            y_r     <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
            sub_r   <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        cnt_r <= '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
                        sub_r   <= sub;
                        carry_r <= sub ? 1'b1 : cin;
`else
                        carry_r <= cin;
`endif
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    res_r   <= res_shift_s;
                    carry_r <= slice_cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_digit_s) begin
                        y_r    <= res_shift_s;
                        cout_r <= slice_cout_s;
`ifdef SERIAL_ADDER_SUBTRACT_EN
                        ovf_r  <= twos_ovf(slice_cmsb_s, slice_cout_s);
`endif
                    end else begin
                        y_r    <= y_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign y    = y_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: W=8/DIGIT=1, W=8/DIGIT=8 and W=16/DIGIT=4 instances
// against an arithmetic reference model; subtract cases run when SERIAL_ADDER_SUBTRACT_EN is defined.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, startf, start16;
    logic [7:0]  a8, b8, y8, yf;
    logic        cin8, sub8, busy8, done8, cout8, ovf8;
    logic        busyf, donef, coutf, ovff;
    logic [15:0] a16, b16, y16;
    logic        cin16, sub16, busy16, done16, cout16, ovf16;

    int errs   = 0;
    int checks = 0;
    logic [7:0]  prev8  = 8'h00;
    logic [15:0] prev16 = 16'h0000;

`ifdef SERIAL_ADDER_SUBTRACT_EN
    serial_adder #(.W(8), .DIGIT(1)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .ovf(ovf8), .busy(busy8), .done(done8), .y(y8), .cout(cout8));
    serial_adder #(.W(8), .DIGIT(8)) dutf (.clk(clk), .rst(rst), .start(startf), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .ovf(ovff), .busy(busyf), .done(donef), .y(yf), .cout(coutf));
    serial_adder #(.W(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .ovf(ovf16), .busy(busy16), .done(done16), .y(y16), .cout(cout16));
`else
    serial_adder #(.W(8), .DIGIT(1)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .y(y8), .cout(cout8));
    serial_adder #(.W(8), .DIGIT(8)) dutf (.clk(clk), .rst(rst), .start(startf), .a(a8), .b(b8),
        .cin(cin8), .busy(busyf), .done(donef), .y(yf), .cout(coutf));
    serial_adder #(.W(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .y(y16), .cout(cout16));
    assign ovf8  = 1'b0;
    assign ovff  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, y} from plain w-bit arithmetic.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] mask, beff, y;
        logic [16:0] s;
        logic        c0, co, ov;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        beff = (sub ? ~b : b) & mask;
        c0   = sub ? 1'b1 : cin;
        s    = {1'b0, a & mask} + {1'b0, beff} + {16'h0000, c0};
        y    = s[15:0] & mask;
        co   = s[w];
        ov   = (a[w-1] == beff[w-1]) && (y[w-1] != a[w-1]);
        return {ov, co, y};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       input bit intrude);
        logic [17:0] e;
        int ndone;
        e = model(8, {8'h00, a}, {8'h00, b}, cin, sub);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub;
        start8 = 1'b1; startf = !intrude;
        @(negedge clk);
        start8 = 1'b0; startf = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        ndone = 0;
        for (int j = 0; j <= 9; j++) begin
            chk("busy8", {31'd0, busy8}, {31'd0, j <= 8});
            chk("done8", {31'd0, done8}, {31'd0, j == 8});
            if (done8) ndone++;
            if (j == 7) chk("y8_hold", {24'd0, y8}, {24'd0, prev8});
            if (j == 8) begin
                chk("y8", {24'd0, y8}, {24'd0, e[7:0]});
                chk("cout8", {31'd0, cout8}, {31'd0, e[16]});
`ifdef SERIAL_ADDER_SUBTRACT_EN
                chk("ovf8", {31'd0, ovf8}, {31'd0, e[17]});
`endif
            end
            if (!intrude) begin
                chk("busyf", {31'd0, busyf}, {31'd0, j <= 1});
                chk("donef", {31'd0, donef}, {31'd0, j == 1});
                if (j == 1) begin
                    chk("yf", {24'd0, yf}, {24'd0, e[7:0]});
                    chk("coutf", {31'd0, coutf}, {31'd0, e[16]});
`ifdef SERIAL_ADDER_SUBTRACT_EN
                    chk("ovff", {31'd0, ovff}, {31'd0, e[17]});
`endif
                end
            end
            if (intrude && j == 3) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        chk("one_done8", ndone, 1);
        prev8 = e[7:0];
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic [17:0] e;
        e = model(16, a, b, cin, sub);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        for (int j = 0; j <= 5; j++) begin
            chk("busy16", {31'd0, busy16}, {31'd0, j <= 4});
            chk("done16", {31'd0, done16}, {31'd0, j == 4});
            if (j == 3) chk("y16_hold", {16'd0, y16}, {16'd0, prev16});
            if (j == 4) begin
                chk("y16", {16'd0, y16}, {16'd0, e[15:0]});
                chk("cout16", {31'd0, cout16}, {31'd0, e[16]});
`ifdef SERIAL_ADDER_SUBTRACT_EN
                chk("ovf16", {31'd0, ovf16}, {31'd0, e[17]});
`endif
            end
            @(negedge clk);
        end
        prev16 = e[15:0];
    endtask

    initial begin
        int nd;
        logic s;
        rst = 1'b0;
        start8 = 1'b1; startf = 1'b1; start16 = 1'b1;
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0;
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b1; sub16 = 1'b0;
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", {29'd0, busy8, busyf, busy16}, 32'd0);
            chk("rst_done", {29'd0, done8, donef, done16}, 32'd0);
            chk("rst_y", {y8, yf, y16}, 32'd0);
            chk("rst_cout", {29'd0, cout8, coutf, cout16}, 32'd0);
        end
        rst = 1'b0; start8 = 1'b0; startf = 1'b0; start16 = 1'b0;
        @(negedge clk);
        chk("idle_busy", {29'd0, busy8, busyf, busy16}, 32'd0);

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);

        // Abort in the middle of a run: outputs clear immediately and no done follows.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_y", {24'd0, y8}, 32'd0);
        chk("abort_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        chk("abort_quiet", nd, 0);
        prev8 = 8'h00;
        prev16 = 16'h0000;
        op8(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUBTRACT_EN
        op8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        op8(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
`endif
        repeat (20) begin
`ifdef SERIAL_ADDER_SUBTRACT_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            op8(8'($urandom), 8'($urandom), 1'($urandom), s, 1'b0);
        end

        op16(16'h1234, 16'hEDCC, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        repeat (10) begin
`ifdef SERIAL_ADDER_SUBTRACT_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            op16(16'($urandom), 16'($urandom), 1'($urandom), s);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
